// File: rtl/mbscore_mem_resp_pkg.sv
// rtl/mbscore_mem_resp_pkg.sv - shared constants and state type for the MBScore memory responder
package mbscore_mem_resp_pkg;

  localparam int MEM_ST_WIDTH = 2;
  localparam int MEM_BE_WIDTH = 4;

  typedef enum logic [MEM_ST_WIDTH-1:0] {
    MEM_ST_IDLE = 2'd0,
    MEM_ST_WAIT = 2'd1,
    MEM_ST_RESP = 2'd2
  } mem_st_e;

endpackage

// File: rtl/mbscore_mem_array.sv
// rtl/mbscore_mem_array.sv - single-port RAM, per-byte write enable, registered read
module mbscore_mem_array
  import mbscore_mem_resp_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                      clk,
  input  logic                      i_rd_en,
  input  logic [MEM_BE_WIDTH-1:0]   i_we,
  input  logic [DEPTH_LOG2-1:0]     i_addr,
  input  logic [8*MEM_BE_WIDTH-1:0] i_wdata,
  output logic [8*MEM_BE_WIDTH-1:0] o_rdata
);

  logic [8*MEM_BE_WIDTH-1:0] r_mem [2**DEPTH_LOG2];
  logic [8*MEM_BE_WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    for (int i = 0; i < MEM_BE_WIDTH; i++) begin
      if (i_we[i]) begin
        r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
      end
    end
    if (i_rd_en) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mbscore_mem_resp.sv
// rtl/mbscore_mem_resp.sv - word-addressed memory responder with programmable wait states
module mbscore_mem_resp
  import mbscore_mem_resp_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [MEM_BE_WIDTH-1:0] req_be,
  output logic                    resp_valid,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic                    resp_err,
  output logic [MEM_ST_WIDTH-1:0] state
);

  localparam int CNT_W = 4;

  mem_st_e                 r_state;
  mem_st_e                 w_state_nxt;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_we;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [MEM_BE_WIDTH-1:0] r_be;
  logic                    r_err;
  logic                    r_rd_ok;

  logic                    w_accept;
  logic                    w_enter_resp;
  logic                    w_use_live;
  logic                    w_we;
  logic [ADDR_WIDTH-1:0]   w_addr;
  logic [DATA_WIDTH-1:0]   w_wdata;
  logic [MEM_BE_WIDTH-1:0] w_be;
  logic                    w_err;
  logic [MEM_BE_WIDTH-1:0] w_ram_we;
  logic                    w_ram_rd;
  logic [DATA_WIDTH-1:0]   w_ram_rdata;

  assign w_accept = (r_state == MEM_ST_IDLE) && req_valid && !rst;

  // With no wait states RESP is entered on the accepting edge, so the live request is used.
  assign w_use_live = (r_state == MEM_ST_IDLE);
  assign w_we       = w_use_live ? req_we    : r_we;
  assign w_addr     = w_use_live ? req_addr  : r_addr;
  assign w_wdata    = w_use_live ? req_wdata : r_wdata;
  assign w_be       = w_use_live ? req_be    : r_be;

  assign w_err = (w_addr[1:0] != 2'b00) || ((w_addr >> (DEPTH_LOG2 + 2)) != '0);

  always_comb begin
    w_state_nxt  = r_state;
    w_enter_resp = 1'b0;
    case (r_state)
      MEM_ST_IDLE: begin
        if (w_accept) begin
          if (WAIT_CYCLES > 0) begin
            w_state_nxt = MEM_ST_WAIT;
          end else begin
            w_state_nxt  = MEM_ST_RESP;
            w_enter_resp = 1'b1;
          end
        end
      end
      MEM_ST_WAIT: begin
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt  = MEM_ST_RESP;
          w_enter_resp = 1'b1;
        end
      end
      MEM_ST_RESP: w_state_nxt = MEM_ST_IDLE;
      default:     w_state_nxt = MEM_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= MEM_ST_IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_err   <= 1'b0;
      r_rd_ok <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_cnt   <= CNT_W'(WAIT_CYCLES);
        r_we    <= req_we;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_be    <= req_be;
      end else if (r_state == MEM_ST_WAIT) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      r_err   <= w_enter_resp && w_err;
      r_rd_ok <= w_enter_resp && !w_we && !w_err;
    end
  end

  // The RAM's read register doubles as the response data register.
  assign w_ram_we = (w_enter_resp && w_we && !w_err) ? w_be : '0;
  assign w_ram_rd = w_enter_resp && !w_we && !w_err;

  mbscore_mem_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk    (clk),
    .i_rd_en(w_ram_rd),
    .i_we   (w_ram_we),
    .i_addr (w_addr[DEPTH_LOG2+1:2]),
    .i_wdata(w_wdata),
    .o_rdata(w_ram_rdata)
  );

  assign req_ready  = (r_state == MEM_ST_IDLE) && !rst;
  assign resp_valid = (r_state == MEM_ST_RESP);
  assign resp_err   = r_err;
  assign resp_rdata = r_rd_ok ? w_ram_rdata : '0;
  assign state      = r_state;

endmodule

// File: tb/tb_mbscore_mem_resp.sv
// tb/tb_mbscore_mem_resp.sv - bench for mbscore_mem_resp with 2 and 0 wait states
module tb_mbscore_mem_resp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        a_req_valid, a_req_we, a_req_ready, a_resp_valid, a_resp_err;
  logic [31:0] a_req_addr, a_req_wdata, a_resp_rdata;
  logic [3:0]  a_req_be;
  logic [1:0]  a_state;

  logic        b_req_valid, b_req_we, b_req_ready, b_resp_valid, b_resp_err;
  logic [31:0] b_req_addr, b_req_wdata, b_resp_rdata;
  logic [3:0]  b_req_be;
  logic [1:0]  b_state;

  mbscore_mem_resp #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_LOG2(10), .WAIT_CYCLES(2)) u_dut_w2 (
    .clk(clk), .rst(rst),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_be(a_req_be),
    .resp_valid(a_resp_valid), .resp_rdata(a_resp_rdata), .resp_err(a_resp_err),
    .state(a_state)
  );

  mbscore_mem_resp #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_LOG2(10), .WAIT_CYCLES(0)) u_dut_w0 (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_be(b_req_be),
    .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata), .resp_err(b_resp_err),
    .state(b_state)
  );

  logic [31:0] ref_mem [2][1024];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int d, input logic v, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be);
    if (d == 0) begin
      a_req_valid = v; a_req_we = we; a_req_addr = addr; a_req_wdata = wdata; a_req_be = be;
    end else begin
      b_req_valid = v; b_req_we = we; b_req_addr = addr; b_req_wdata = wdata; b_req_be = be;
    end
  endtask

  function automatic logic ready_of(input int d);
    return (d == 0) ? a_req_ready : b_req_ready;
  endfunction
  function automatic logic rv_of(input int d);
    return (d == 0) ? a_resp_valid : b_resp_valid;
  endfunction
  function automatic logic err_of(input int d);
    return (d == 0) ? a_resp_err : b_resp_err;
  endfunction
  function automatic logic [31:0] rd_of(input int d);
    return (d == 0) ? a_resp_rdata : b_resp_rdata;
  endfunction
  function automatic logic [1:0] st_of(input int d);
    return (d == 0) ? a_state : b_state;
  endfunction

  // Reference: 4 KiB byte-lane memory; misaligned or out-of-range requests are errors.
  task automatic model(input int d, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, output logic err, output logic [31:0] rd);
    int idx;
    err = (addr % 4 != 0) || (addr >= 32'd4096);
    rd  = 32'h0;
    if (!err) begin
      idx = int'(addr / 4);
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) ref_mem[d][idx][8*i +: 8] = wdata[8*i +: 8];
        end
      end else begin
        rd = ref_mem[d][idx];
      end
    end
  endtask

  task automatic xact(input int d, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be, input string tag);
    logic        exp_err;
    logic [31:0] exp_rd;
    logic [1:0]  st1;
    int          lat;
    bit          got;
    st1 = 2'd3;
    @(negedge clk);
    drive(d, 1'b1, we, addr, wdata, be);
    got = 0;
    for (int i = 0; i < 20; i++) begin
      if (ready_of(d)) begin got = 1; break; end
      @(negedge clk);
    end
    if (!got) begin
      chk({tag, " accept_timeout"}, 32'd0, 32'd1);
      drive(d, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      return;
    end
    @(posedge clk);
    #1;
    drive(d, 1'b0, 1'($urandom), $urandom, $urandom, 4'($urandom));
    model(d, we, addr, wdata, be, exp_err, exp_rd);
    got = 0;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      lat++;
      if (i == 0) st1 = st_of(d);
      if (rv_of(d)) begin got = 1; break; end
    end
    if (!got) begin
      chk({tag, " resp_timeout"}, 32'd0, 32'd1);
      return;
    end
    chk({tag, " latency"}, 32'(lat), (d == 0) ? 32'd3 : 32'd1);
    chk({tag, " state_after_accept"}, 32'(st1), (d == 0) ? 32'd1 : 32'd2);
    chk({tag, " err"}, 32'(err_of(d)), 32'(exp_err));
    chk({tag, " rdata"}, rd_of(d), exp_rd);
  endtask

  logic        s_we   [8];
  logic [31:0] s_addr [8];
  logic [31:0] s_wd   [8];
  logic [3:0]  s_be   [8];
  logic [32:0] exp_q [$];

  initial begin
    logic [31:0] addr;
    logic [32:0] e;
    logic        e_err;
    logic [31:0] e_rd;
    logic        acc;
    int          k;

    rst = 1'b0;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

    #3 rst = 1'b1;
    #4;
    chk("rst a_ready", 32'(a_req_ready), 32'd0);
    chk("rst b_ready", 32'(b_req_ready), 32'd0);
    chk("rst a_state", 32'(a_state), 32'd0);
    chk("rst a_resp_valid", 32'(a_resp_valid), 32'd0);
    chk("rst a_rdata", a_resp_rdata, 32'h0);
    chk("rst a_err", 32'(a_resp_err), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(negedge clk);
    chk("post_rst a_ready", 32'(a_req_ready), 32'd1);
    chk("post_rst b_ready", 32'(b_req_ready), 32'd1);
    chk("post_rst b_state", 32'(b_state), 32'd0);

    xact(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, "st10_full");
    xact(0, 1'b0, 32'h10, 32'h0, 4'h0, "ld10_full");
    xact(0, 1'b1, 32'h10, 32'h00000055, 4'h1, "st10_lane0");
    xact(0, 1'b0, 32'h10, 32'h0, 4'h0, "ld10_merged");
    xact(0, 1'b0, 32'h12, 32'h0, 4'h0, "ld_misaligned");
    xact(0, 1'b1, 32'h0, 32'hCAFEF00D, 4'hF, "st00");
    xact(0, 1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, "st_out_of_range");
    xact(0, 1'b0, 32'h0, 32'h0, 4'h0, "ld00_untouched");
    xact(0, 1'b1, 32'h10, 32'h11111111, 4'h0, "st10_be0");
    xact(0, 1'b0, 32'h10, 32'h0, 4'h0, "ld10_after_be0");
    xact(0, 1'b1, 32'h20, 32'h12345678, 4'hF, "st20_prior");

    // Store aborted by reset while waiting: no response and no write.
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 32'h20, 32'hAAAA5555, 4'hF);
    chk("abort ready", 32'(a_req_ready), 32'd1);
    @(posedge clk);
    #1 drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    chk("abort in_wait", 32'(a_state), 32'd1);
    #2 rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort resp_valid", 32'(a_resp_valid), 32'd0);
      chk("abort state", 32'(a_state), 32'd0);
    end
    @(posedge clk);
    #3 rst = 1'b0;
    xact(0, 1'b0, 32'h20, 32'h0, 4'h0, "ld20_after_abort");

    for (int i = 0; i < 8; i++) begin
      xact(0, 1'b1, 32'h100 + 32'(4 * i), $urandom, 4'hF, "fillA");
    end
    for (int i = 0; i < 20; i++) begin
      addr = 32'h100 + 32'(4 * $urandom_range(0, 7));
      case ($urandom_range(0, 7))
        0:       addr = addr | 32'($urandom_range(1, 3));
        1:       addr = ($urandom | 32'h1000) & 32'hFFFF_FFFC;
        default: ;
      endcase
      xact(0, 1'($urandom), addr, $urandom, 4'($urandom), "rndA");
    end

    xact(1, 1'b1, 32'h40, 32'h0BADF00D, 4'hF, "b_st40");
    xact(1, 1'b0, 32'h40, 32'h0, 4'h0, "b_ld40");

    // Back-to-back with req_valid held high: one accept every other cycle.
    for (int i = 0; i < 8; i++) begin
      if (i < 4) begin
        s_we[i] = 1'b1; s_be[i] = 4'hF;
      end else begin
        s_we[i] = 1'($urandom); s_be[i] = 4'($urandom);
      end
      s_addr[i] = 32'h40 + 32'(4 * (i % 4));
      s_wd[i]   = $urandom;
    end
    k = 0;
    @(negedge clk);
    drive(1, 1'b1, s_we[0], s_addr[0], s_wd[0], s_be[0]);
    for (int c = 0; c < 16; c++) begin
      chk("bp ready", 32'(b_req_ready), (c % 2 == 0) ? 32'd1 : 32'd0);
      chk("bp resp_valid", 32'(b_resp_valid), (c % 2 == 1) ? 32'd1 : 32'd0);
      if (b_resp_valid) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("bp err", 32'(b_resp_err), 32'(e[32]));
          chk("bp rdata", b_resp_rdata, e[31:0]);
        end else begin
          chk("bp unexpected_resp", 32'd1, 32'd0);
        end
      end
      acc = b_req_ready && b_req_valid;
      @(posedge clk);
      #1;
      if (acc) begin
        model(1, s_we[k], s_addr[k], s_wd[k], s_be[k], e_err, e_rd);
        exp_q.push_back({e_err, e_rd});
        k++;
        if (k < 8) drive(1, 1'b1, s_we[k], s_addr[k], s_wd[k], s_be[k]);
        else       drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      end
      @(negedge clk);
    end
    chk("bp accepted", 32'(k), 32'd8);
    chk("bp drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
